// File: rtl/layer_controller_pkg.sv
// Shared types and helpers for the layer sequencer and its activation stage.
package layer_controller_pkg;

    // Pass sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SEND      = 2'd2
    } state_t;

    // Low bit index of a given lane within a flat packed vector of equal lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/nn_activation_clamp.sv
// Clamping activation for one neuron lane: negatives go to zero, values above
// the activation range saturate, and the result is zero-extended to sum width.
module nn_activation_clamp
    import layer_controller_pkg::*;
#(
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9
) (
    input  logic [NEURON_OUTPUT_WIDTH-1:0] sum,
    output logic [NEURON_OUTPUT_WIDTH-1:0] act
);

    localparam logic [NEURON_OUTPUT_WIDTH-1:0] ACT_MAX =
        {{(NEURON_OUTPUT_WIDTH-ACTIVATION_WIDTH){1'b0}}, {ACTIVATION_WIDTH{1'b1}}};

    // Sign bit set means negative; otherwise saturate against the activation maximum.
    always_comb begin
        act = sum;
        if (sum[NEURON_OUTPUT_WIDTH-1]) begin
            act = '0;
        end else if (sum > ACT_MAX) begin
            act = ACT_MAX;
        end
    end

endmodule

// File: rtl/layer_controller.sv
// Sequencer for the time-multiplexed layer datapath: buffers network inputs and
// previous-layer sums, selects the source for each requested layer pass and
// presents it to the layer module over a valid/ready handshake.
module layer_controller
    import layer_controller_pkg::*;
#(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int LAYER_ADDR_WIDTH    = 1,
    parameter int LAYER_MAX           = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    start_inputs,
    input  logic                                      start_inputs_valid,
    output logic                                      start_inputs_ready,
    input  logic [LAYER_ADDR_WIDTH-1:0]               layer_number,
    input  logic                                      layer_number_valid,
    output logic                                      layer_number_ready,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_outputs,
    input  logic                                      layer_outputs_valid,
    output logic                                      layer_outputs_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_inputs,
    output logic                                      layer_inputs_valid,
    input  logic                                      layer_inputs_ready
);

    state_t                                  state;
    logic [LAYER_ADDR_WIDTH-1:0]             cur_layer;
    logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] result;

    logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    start_buf;
    logic                                      start_full;
    logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] out_buf;
    logic                                      out_full;

    logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] start_ext;
    logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] act_vec;

    logic load_start;
    logic load_out;
    logic layer_in_range;

    // Handshake outputs are pure decodes of registered state, never of inputs.
    assign start_inputs_ready  = !start_full;
    assign layer_outputs_ready = !out_full;
    assign layer_number_ready  = (state == IDLE);
    assign layer_inputs_valid  = (state == SEND);
    assign layer_inputs        = result;

    // A buffer is drained only on the WAIT_DATA edge that loads the result.
    assign load_start     = (state == WAIT_DATA) && (cur_layer == '0) && start_full;
    assign load_out       = (state == WAIT_DATA) && (cur_layer != '0) && out_full;
    assign layer_in_range = (32'(layer_number) < LAYER_MAX);

    // Per-lane source preparation: zero-extended network inputs and clamped sums.
    for (genvar i = 0; i < NEURON_NUM; i++) begin : g_lane
        assign start_ext[lane_lo(i, NEURON_OUTPUT_WIDTH) +: NEURON_OUTPUT_WIDTH] =
            {{(NEURON_OUTPUT_WIDTH-ACTIVATION_WIDTH){1'b0}},
             start_buf[lane_lo(i, ACTIVATION_WIDTH) +: ACTIVATION_WIDTH]};

        nn_activation_clamp #(
            .NEURON_OUTPUT_WIDTH (NEURON_OUTPUT_WIDTH),
            .ACTIVATION_WIDTH    (ACTIVATION_WIDTH)
        ) u_clamp (
            .sum (out_buf[lane_lo(i, NEURON_OUTPUT_WIDTH) +: NEURON_OUTPUT_WIDTH]),
            .act (act_vec[lane_lo(i, NEURON_OUTPUT_WIDTH) +: NEURON_OUTPUT_WIDTH])
        );
    end

    // Network-input buffer: fills whenever empty, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_buf  <= '0;
            start_full <= 1'b0;
        end else if (start_inputs_valid && !start_full) begin
            start_buf  <= start_inputs;
            start_full <= 1'b1;
        end else if (load_start) begin
            start_full <= 1'b0;
        end
    end

    // Previous-layer sums buffer: fills whenever empty, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (layer_outputs_valid && !out_full) begin
            out_buf  <= layer_outputs;
            out_full <= 1'b1;
        end else if (load_out) begin
            out_full <= 1'b0;
        end
    end

    // Pass sequencer: accept a layer number, wait for its source, present the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_layer <= '0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (layer_number_valid && layer_in_range) begin
                        cur_layer <= layer_number;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (load_start) begin
                        result <= start_ext;
                        state  <= SEND;
                    end else if (load_out) begin
                        result <= act_vec;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (layer_inputs_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_controller.sv
// Scoreboard bench for layer_controller: stimulus pushes hand-computed vectors,
// a monitor pops and compares them on every output handshake.
module tb_layer_controller;

    localparam int N   = 5;
    localparam int SW  = 10;
    localparam int AW  = 9;
    localparam int LAW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*AW-1:0]   start_inputs = '0;
    logic              start_inputs_valid = 1'b0;
    logic              start_inputs_ready;
    logic [LAW-1:0]    layer_number = '0;
    logic              layer_number_valid = 1'b0;
    logic              layer_number_ready;
    logic [N*SW-1:0]   layer_outputs = '0;
    logic              layer_outputs_valid = 1'b0;
    logic              layer_outputs_ready;
    logic [N*SW-1:0]   layer_inputs;
    logic              layer_inputs_valid;
    logic              layer_inputs_ready = 1'b0;

    int passed = 0;
    int total  = 0;
    logic [N*SW-1:0] sb[$];
    logic [N*SW-1:0] hold_vec;

    layer_controller #(
        .NEURON_NUM          (N),
        .NEURON_OUTPUT_WIDTH (SW),
        .ACTIVATION_WIDTH    (AW),
        .LAYER_ADDR_WIDTH    (LAW),
        .LAYER_MAX           (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_inputs        (start_inputs),
        .start_inputs_valid  (start_inputs_valid),
        .start_inputs_ready  (start_inputs_ready),
        .layer_number        (layer_number),
        .layer_number_valid  (layer_number_valid),
        .layer_number_ready  (layer_number_ready),
        .layer_outputs       (layer_outputs),
        .layer_outputs_valid (layer_outputs_valid),
        .layer_outputs_ready (layer_outputs_ready),
        .layer_inputs        (layer_inputs),
        .layer_inputs_valid  (layer_inputs_valid),
        .layer_inputs_ready  (layer_inputs_ready)
    );

    always #5 clk = ~clk;

    // Lane 4 is the leftmost argument, lane 0 the rightmost.
    function automatic logic [N*SW-1:0] packSums(input int l4, input int l3, input int l2,
                                                 input int l1, input int l0);
        logic [N*SW-1:0] v;
        v = {10'(l4), 10'(l3), 10'(l2), 10'(l1), 10'(l0)};
        return v;
    endfunction

    function automatic logic [N*AW-1:0] packStart(input int l4, input int l3, input int l2,
                                                  input int l1, input int l0);
        logic [N*AW-1:0] v;
        v = {9'(l4), 9'(l3), 9'(l2), 9'(l1), 9'(l0)};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Output monitor: every handshake on layer_inputs is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && layer_inputs_valid && layer_inputs_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected output", 64'(layer_inputs_valid), 64'd0);
            end else begin
                hold_vec = sb.pop_front();
                checkOutput("layer_inputs data", 64'(layer_inputs), 64'(hold_vec));
            end
        end
    end

    task automatic pulseStart(input logic [N*AW-1:0] v);
        @(posedge clk); #1;
        start_inputs = v;
        start_inputs_valid = 1'b1;
        @(posedge clk); #1;
        start_inputs_valid = 1'b0;
    endtask

    task automatic pulseOutputs(input logic [N*SW-1:0] v);
        @(posedge clk); #1;
        layer_outputs = v;
        layer_outputs_valid = 1'b1;
        @(posedge clk); #1;
        layer_outputs_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [LAW-1:0] n);
        @(posedge clk); #1;
        layer_number = n;
        layer_number_valid = 1'b1;
        @(posedge clk); #1;
        layer_number_valid = 1'b0;
    endtask

    task automatic waitValid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (layer_inputs_valid) break;
        end
        checkOutput(name, 64'(layer_inputs_valid), 64'd1);
    endtask

    task automatic consume();
        @(posedge clk); #1;
        layer_inputs_ready = 1'b1;
        @(posedge clk); #1;
        layer_inputs_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("reset number_ready", 64'(layer_number_ready), 64'd1);
        checkOutput("reset start_ready", 64'(start_inputs_ready), 64'd1);
        checkOutput("reset outputs_ready", 64'(layer_outputs_ready), 64'd1);
        checkOutput("reset valid", 64'(layer_inputs_valid), 64'd0);
        checkOutput("reset layer_inputs", 64'(layer_inputs), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Layer 0 from buffered network inputs
        pulseStart(packStart(5, 4, 3, 2, 1));
        @(negedge clk);
        checkOutput("start_ready after fill", 64'(start_inputs_ready), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("no output before number", 64'(layer_inputs_valid), 64'd0);
        sb.push_back(packSums(5, 4, 3, 2, 1));
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("L0 valid one cycle after number", 64'(layer_inputs_valid), 64'd0);
        @(negedge clk);
        checkOutput("L0 valid two cycles after number", 64'(layer_inputs_valid), 64'd1);
        checkOutput("L0 number_ready in SEND", 64'(layer_number_ready), 64'd0);
        checkOutput("L0 start_ready after load", 64'(start_inputs_ready), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("L0 valid held", 64'(layer_inputs_valid), 64'd1);
        consume();
        @(negedge clk);
        checkOutput("L0 valid after consume", 64'(layer_inputs_valid), 64'd0);
        checkOutput("L0 number_ready after consume", 64'(layer_number_ready), 64'd1);

        // Sums arriving before their layer number
        pulseOutputs(packSums(350, 300, 250, 200, 150));
        repeat (3) @(negedge clk);
        checkOutput("early sums no output", 64'(layer_inputs_valid), 64'd0);
        checkOutput("early sums outputs_ready", 64'(layer_outputs_ready), 64'd0);
        sb.push_back(packSums(350, 300, 250, 200, 150));
        applyStimulus(1'b1);
        waitValid("early sums valid");
        consume();

        // Clamp: 512 is not representable in 10-bit signed lanes and wraps to -512
        pulseOutputs(packSums(-1, 0, 511, 512, -512));
        sb.push_back(packSums(0, 0, 511, 0, 0));
        applyStimulus(1'b1);
        waitValid("clamp valid");
        consume();

        // Mixed clamp lanes
        pulseOutputs(packSums(100, -20, 480, 7, -300));
        sb.push_back(packSums(100, 0, 480, 7, 0));
        applyStimulus(1'b1);
        waitValid("mixed valid");
        consume();

        // Number and data on the same edge
        @(posedge clk); #1;
        layer_number = 1'b1;
        layer_number_valid = 1'b1;
        layer_outputs = packSums(1, 2, 3, 4, 5);
        layer_outputs_valid = 1'b1;
        sb.push_back(packSums(1, 2, 3, 4, 5));
        @(posedge clk); #1;
        layer_number_valid = 1'b0;
        layer_outputs_valid = 1'b0;
        @(negedge clk);
        checkOutput("simul number accepted", 64'(layer_number_ready), 64'd0);
        checkOutput("simul data accepted", 64'(layer_outputs_ready), 64'd0);
        @(negedge clk);
        checkOutput("simul valid", 64'(layer_inputs_valid), 64'd1);
        consume();

        // Back-pressure then reset mid-SEND
        pulseOutputs(packSums(10, 20, 30, 40, 50));
        sb.push_back(packSums(10, 20, 30, 40, 50));
        applyStimulus(1'b1);
        waitValid("backpressure valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("backpressure data stable", 64'(layer_inputs),
                        64'(packSums(10, 20, 30, 40, 50)));
            checkOutput("backpressure number_ready", 64'(layer_number_ready), 64'd0);
        end
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("async reset valid", 64'(layer_inputs_valid), 64'd0);
        checkOutput("async reset data", 64'(layer_inputs), 64'd0);
        checkOutput("async reset number_ready", 64'(layer_number_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery pass on layer 0 with zero-extension of full-range lanes
        pulseStart(packStart(511, 0, 256, 1, 100));
        sb.push_back(packSums(511, 0, 256, 1, 100));
        applyStimulus(1'b0);
        waitValid("recovery valid");
        consume();

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
